// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port data memory between instruction fetch (IF, read-only)
//   and the load/store unit (LS, read/write). Round-robin arbitration on a
//   valid/ready request handshake, one transaction in flight at a time.
//
//   Transaction timeline (handshake in cycle T):
//     T+1                 ISSUE : mem_en pulse, address/data driven
//     T+2 .. T+1+MEM_LAT  WAIT  : address/data held, read_data captured in last cycle
//     T+2+MEM_LAT         RESP  : one-cycle resp_valid pulse to the owner
//     T+3+MEM_LAT         IDLE  : next request may be accepted
//
// Ports
//   clk, rst                         clock, synchronous active-low reset
//   if_req_valid/ready, if_addr      IF read request
//   if_resp_valid, if_resp_data      IF read response (data holds after pulse)
//   ls_req_valid/ready, ls_we,
//   ls_addr, ls_wdata                LS read/write request
//   ls_resp_valid, ls_resp_data      LS response (data 0 for write acks)
//   mem_en, rd_wr, read_addr,
//   write_addr, write_data           memory command pins
//   read_data                        memory read data

module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // Instruction fetch port
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_resp_data,
    // Load/store port
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_resp_valid,
    output logic [DATA_WIDTH-1:0] ls_resp_data,
    // Memory side
    output logic                  mem_en,
    output logic                  rd_wr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data
);

    localparam int unsigned CntW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam int unsigned LastWait = (MEM_LAT < 1) ? 0 : MEM_LAT - 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LastWait);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        PortIf = 1'b0,
        PortLs = 1'b1
    } port_e;

    state_e                state_q, state_d;
    port_e                 last_grant_q, last_grant_d;
    port_e                 owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

    logic                  sel_if;
    logic                  sel_ls;
    logic                  in_idle;
    logic                  handshake;
    logic                  mem_act;
    logic [DATA_WIDTH-1:0] captured;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last wins. Exactly one of sel_if/sel_ls can be high.
    // ------------------------------------------------------------------
    always_comb begin
        sel_if = if_req_valid && (!ls_req_valid || (last_grant_q == PortLs));
        sel_ls = ls_req_valid && !sel_if;
    end

    // Readies are masked while reset is asserted so nothing can be accepted
    // in the cycle that precedes the resetting edge.
    assign in_idle      = rst && (state_q == StIdle);
    assign if_req_ready = in_idle && sel_if;
    assign ls_req_ready = in_idle && sel_ls;
    assign handshake    = (if_req_valid && if_req_ready) || (ls_req_valid && ls_req_ready);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        captured     = we_q ? '0 : read_data;

        case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d = StIssue;
                    if (sel_if) begin
                        owner_d      = PortIf;
                        last_grant_d = PortIf;
                        we_d         = 1'b0;
                        addr_d       = if_addr;
                        wdata_d      = '0;
                    end else begin
                        owner_d      = PortLs;
                        last_grant_d = PortLs;
                        we_d         = ls_we;
                        addr_d       = ls_addr;
                        wdata_d      = ls_we ? ls_wdata : '0;
                    end
                end
            end

            StIssue: begin
                state_d = StWait;
                cnt_d   = '0;
            end

            StWait: begin
                if (cnt_q == CntLast) begin
                    // Last wait cycle: memory data is valid now, capture it
                    // straight into the owner's response register.
                    state_d = StResp;
                    if (owner_q == PortIf) begin
                        if_rdata_d = captured;
                    end else begin
                        ls_rdata_d = captured;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= PortLs;
            owner_q      <= PortIf;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory command outputs: driven through ISSUE and WAIT, zero otherwise.
    // The address/data bus not used by the current direction stays zero.
    // ------------------------------------------------------------------
    assign mem_act = rst && ((state_q == StIssue) || (state_q == StWait));

    always_comb begin
        mem_en     = rst && (state_q == StIssue);
        rd_wr      = mem_act && we_q;
        read_addr  = '0;
        write_addr = '0;
        write_data = '0;
        if (mem_act) begin
            if (we_q) begin
                write_addr = addr_q;
                write_data = wdata_q;
            end else begin
                read_addr = addr_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------
    assign if_resp_valid = rst && (state_q == StResp) && (owner_q == PortIf);
    assign ls_resp_valid = rst && (state_q == StResp) && (owner_q == PortLs);
    assign if_resp_data  = if_rdata_q;
    assign ls_resp_data  = ls_rdata_q;

`ifndef SYNTHESIS
    // Both requesters must never see ready in the same cycle.
    a_ready_onehot : assert property (@(posedge clk) !(if_req_ready && ls_req_ready));
    // A memory command is only ever issued from the ISSUE state.
    a_mem_en_issue : assert property (@(posedge clk) mem_en |-> (state_q == StIssue));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (MEM_LAT = 1).
// Drivers push expected memory commands and responses into queues at each
// handshake; a negedge monitor pops and compares whenever the DUT presents
// mem_en or a resp_valid pulse.

module tb_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [AW-1:0] if_addr = '0;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_data;
    logic          ls_req_valid = 1'b0;
    logic          ls_req_ready;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_resp_data;
    logic          mem_en;
    logic          rd_wr;
    logic [AW-1:0] read_addr;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    mem_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_LAT    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_we         (ls_we),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_data  (ls_resp_data),
        .mem_en        (mem_en),
        .rd_wr         (rd_wr),
        .read_addr     (read_addr),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got a pulse, expected none (cycle %0d)", name, cyc);
    endfunction

    // ------------------------------------------------------------------
    // Memory model: one-cycle synchronous read, word indexed by addr[9:2]
    // ------------------------------------------------------------------
    logic [31:0] mem [0:255];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[64]  <= 32'h1111_0100;   // 0x100
            mem[65]  <= 32'h2222_0104;   // 0x104
            mem_init <= 1'b1;
        end else if (mem_en) begin
            if (rd_wr) mem[write_addr[9:2]] <= write_data;
            else       read_data <= mem[read_addr[9:2]];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard queues
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic        port;   // 0 = IF, 1 = LS
        logic [31:0] cyc;
    } hs_t;

    iss_t iss_q[$];
    rsp_t if_q[$];
    rsp_t ls_q[$];
    hs_t  hs_log[$];

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    iss_t        mon_e;
    rsp_t        mon_r;
    bit          if_hold = 1'b0;
    bit          ls_hold = 1'b0;
    logic [31:0] if_last = '0;
    logic [31:0] ls_last = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_mem_en", 32'(mem_en), 32'h0);
            check("rst_if_ready", 32'(if_req_ready), 32'h0);
            check("rst_ls_ready", 32'(ls_req_ready), 32'h0);
            check("rst_if_resp_valid", 32'(if_resp_valid), 32'h0);
            check("rst_ls_resp_valid", 32'(ls_resp_valid), 32'h0);
            if_hold = 1'b0;
            ls_hold = 1'b0;
        end else begin
            if (if_req_ready && ls_req_ready) unexpected("both_ready");

            if (mem_en) begin
                if (iss_q.size() == 0) begin
                    unexpected("mem_en_unexpected");
                end else begin
                    mon_e = iss_q.pop_front();
                    check("mem_en_cycle", cyc, mon_e.cyc);
                    check("mem_rd_wr", 32'(rd_wr), 32'(mon_e.we));
                    check("mem_read_addr", read_addr, mon_e.we ? 32'h0 : mon_e.addr);
                    check("mem_write_addr", write_addr, mon_e.we ? mon_e.addr : 32'h0);
                    check("mem_write_data", write_data, mon_e.wdata);
                end
            end

            if (if_hold) check("if_resp_data_hold", if_resp_data, if_last);
            if_hold = 1'b0;
            if (if_resp_valid) begin
                if (if_q.size() == 0) begin
                    unexpected("if_resp_unexpected");
                end else begin
                    mon_r = if_q.pop_front();
                    check("if_resp_cycle", cyc, mon_r.cyc);
                    check("if_resp_data", if_resp_data, mon_r.data);
                    if_hold = 1'b1;
                    if_last = mon_r.data;
                end
            end

            if (ls_hold) check("ls_resp_data_hold", ls_resp_data, ls_last);
            ls_hold = 1'b0;
            if (ls_resp_valid) begin
                if (ls_q.size() == 0) begin
                    unexpected("ls_resp_unexpected");
                end else begin
                    mon_r = ls_q.pop_front();
                    check("ls_resp_cycle", cyc, mon_r.cyc);
                    check("ls_resp_data", ls_resp_data, mon_r.data);
                    ls_hold = 1'b1;
                    ls_last = mon_r.data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (called #1 after a posedge; return #1 after the accept edge)
    // ------------------------------------------------------------------
    task automatic if_req(input logic [31:0] a, input logic [31:0] exp, input bit want_resp);
        int   guard;
        iss_t e;
        rsp_t r;
        hs_t  h;
        guard        = 0;
        if_req_valid = 1'b1;
        if_addr      = a;
        @(negedge clk);
        while (!if_req_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!if_req_ready) begin
            checks++;
            failures++;
            $display("FAIL if_accept_timeout: got ready=0, expected ready=1 within 200 cycles");
        end else begin
            e.cyc = cyc + 1; e.we = 1'b0; e.addr = a; e.wdata = '0;
            iss_q.push_back(e);
            if (want_resp) begin
                r.cyc = cyc + 3; r.data = exp;
                if_q.push_back(r);
            end
            h.port = 1'b0; h.cyc = cyc;
            hs_log.push_back(h);
        end
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
    endtask

    task automatic ls_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp, input bit want_resp);
        int   guard;
        iss_t e;
        rsp_t r;
        hs_t  h;
        guard        = 0;
        ls_req_valid = 1'b1;
        ls_we        = we;
        ls_addr      = a;
        ls_wdata     = wd;
        @(negedge clk);
        while (!ls_req_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!ls_req_ready) begin
            checks++;
            failures++;
            $display("FAIL ls_accept_timeout: got ready=0, expected ready=1 within 200 cycles");
        end else begin
            e.cyc = cyc + 1; e.we = we; e.addr = a; e.wdata = we ? wd : 32'h0;
            iss_q.push_back(e);
            if (want_resp) begin
                r.cyc = cyc + 3; r.data = exp;
                ls_q.push_back(r);
            end
            h.port = 1'b1; h.cyc = cyc;
            hs_log.push_back(h);
        end
        @(posedge clk);
        #1;
        ls_req_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [31:0] rel;
    logic [31:0] c0;
    logic [3:0]  exp_port;

    initial begin
        // Test 1: reset held two cycles with both requesters valid
        rst          = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 32'h100;
        ls_req_valid = 1'b1;
        ls_we        = 1'b1;
        ls_addr      = 32'h200;
        ls_wdata     = 32'hCAFE_0001;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rel = cyc;

        // Test 4: both valid continuously from reset -> IF, LS, IF, LS every 4 cycles
        fork
            begin
                if_req(32'h100, 32'h1111_0100, 1'b1);
                if_req(32'h104, 32'h2222_0104, 1'b1);
            end
            begin
                ls_req(1'b1, 32'h200, 32'hCAFE_0001, 32'h0, 1'b1);
                ls_req(1'b0, 32'h200, 32'h0, 32'hCAFE_0001, 1'b1);
            end
        join
        exp_port = 4'b1010;
        check("t4_grant_count", 32'(hs_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
            check("t4_grant_port", 32'(hs_log[i].port), 32'(exp_port[i]));
            check("t4_grant_cycle", hs_log[i].cyc, rel + 32'(4 * i));
        end
        repeat (6) @(posedge clk);
        #1;

        // Test 2: LS write 0x10 <- 0x12345678, ack data 0
        ls_req(1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Test 3: IF read 0x10 returns the word just written
        if_req(32'h10, 32'h1234_5678, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Test 5: LS valid held through an IF transaction is accepted at IDLE only
        hs_log.delete();
        fork
            if_req(32'h100, 32'h1111_0100, 1'b1);
            begin
                @(posedge clk);
                #1;
                ls_req(1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b1);
            end
        join
        check("t5_grant_count", 32'(hs_log.size()), 32'd2);
        if (hs_log.size() == 2) begin
            check("t5_first_port", 32'(hs_log[0].port), 32'h0);
            check("t5_second_port", 32'(hs_log[1].port), 32'h1);
            check("t5_ls_accept_gap", hs_log[1].cyc - hs_log[0].cyc, 32'd4);
        end
        repeat (5) @(posedge clk);
        #1;

        // Test 6: reset during WAIT aborts; no response, next request normal
        if_req(32'h104, 32'h0, 1'b0);   // returns in ISSUE cycle
        @(posedge clk);
        #1;
        rst = 1'b0;                      // asserted through the WAIT cycle
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        hs_log.delete();
        c0 = cyc;
        if_req(32'h104, 32'h2222_0104, 1'b1);
        check("t6_accept_after_reset", hs_log.size() > 0 ? hs_log[0].cyc : 32'hFFFF_FFFF, c0);
        repeat (6) @(posedge clk);
        #1;

        check("end_iss_q_empty", 32'(iss_q.size()), 32'h0);
        check("end_if_q_empty", 32'(if_q.size()), 32'h0);
        check("end_ls_q_empty", 32'(ls_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
